resource_arbiter_ctrl: RTL and testbench
========================================

Name: resource_arbiter_ctrl

Overview:
- Time-multiplexes the single shared resource between NUM_REQ pipeline requesters using a round-robin scheme.
- Each grant is held for a fixed occupancy window of HOLD_CYCLES. An owner may extend its grant with lock, bounded by a starvation watchdog.
- Per-requester flush cancels outstanding requests and aborts an active grant.
- Sits between the pipeline_top instances and shared_resource. Drives the input-mux select and the stall feedback.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- HOLD_CYCLES, 1, cycles per grant window (1..255).
- MAX_WAIT, 8, waiting cycles after which a requester is starved (2..255).
- ID_W, $clog2(NUM_REQ) (min 1), width of owner_id.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester resource request (level).
- lock  in  NUM_REQ  owner asks to keep the grant past the current window.
- flush  in  NUM_REQ  per-requester flush; cancels request/grant.
- grant  out  NUM_REQ  one-hot or zero; registered.
- owner_id  out  ID_W  index of current owner; valid when busy.
- busy  out  1  a grant is active.
- stall  out  NUM_REQ  combinational: req & ~flush & ~grant.
- starved  out  NUM_REQ  registered: wait counter has reached MAX_WAIT.

Behaviour:
- Reset (reset=0, async): grant=0, owner_id=0, busy=0, starved=0, all wait counters=0, RR pointer=0, state=IDLE. stall follows its equation.
- Effective request: ereq = req & ~flush.

State IDLE:
- If ereq != 0 at edge t: pick winner W, load hold counter = HOLD_CYCLES-1, go to HOLD.
- grant[W], busy and owner_id are visible from cycle t+1, so request-to-grant latency is 1 cycle.

State HOLD:
- grant stays constant. Counter decrements each cycle; the window ends on the cycle with counter==0.
- At the window end:
  - Extend: if lock[owner] & ereq[owner] and no other requester is starved, reload the counter and keep the owner. The RR pointer does not move.
  - Otherwise release: the pointer moves to owner+1 (mod NUM_REQ).
    - If ereq from any requester (including the old owner) is nonzero, re-arbitrate in the same edge. The new grant starts the next cycle, back-to-back with no bubble.
    - Else go to IDLE with grant=0.
- Owner flush or owner req drop during HOLD: abort at that edge. grant=0 the next cycle, the pointer moves to owner+1, state goes to IDLE. No same-edge re-arbitration.

Winner selection:
- If any ereq bit has starved=1, the lowest such index wins.
- Else the first set ereq bit at or after the pointer wins, circular search.

Wait counters (per requester i):
- Cleared when grant[i]=1, or ereq[i]=0.
- Otherwise incremented each cycle, saturating at MAX_WAIT.
- starved[i] = (count==MAX_WAIT), registered. It clears the cycle after grant[i] or after a req drop or flush.

Boundary cases:
- HOLD_CYCLES=1: every window is one cycle. With continuous requests, grants alternate every cycle.
- Flush of a non-owner: removes its request only; the owner is unaffected.
- lock on a non-owner is ignored. lock without req does not extend.
- Simultaneous window end and owner flush: abort rule wins. No same-edge re-arbitration.
- Invariants: grant is always one-hot or zero. owner_id equals the grant index while busy. busy == |grant.
- Reset mid-HOLD drops grant immediately (async).

Test Plan (NUM_REQ=2, HOLD_CYCLES=3, MAX_WAIT=4 unless noted):
1. Reset, then req=01 at cycle 0 -> grant=01 for cycles 1-3, busy=1, owner_id=0; grant=00 at cycle 4 if req drops at cycle 3.
2. req=11 held constant -> grant 01 for cycles 1-3, then 10 for cycles 4-6, then 01 for cycles 7-9; no bubble; stall is the complement of grant.
3. req=11, lock=01 held -> req1 waits; starved[1]=1 at cycle 5; owner 0 keeps its extension at cycle 3; at cycle 6 the extension is refused and grant=10 from cycle 7; starved[1]=0 at cycle 8.
4. req=11, owner 0 in HOLD, flush=01 at cycle 2 -> grant=00 at cycle 3, IDLE; grant=10 at cycle 4.
5. flush=10 while req=11 from IDLE -> grant=01 only; stall[1]=0; wait counter 1 stays 0.
6. Assert reset=0 mid-HOLD (cycle 2) -> grant, busy and starved read 0 immediately; after release with req=10, grant=10 one cycle later (pointer reset to 0, requester 1 first set bit).

Source files
------------

// File: rtl/resource_arbiter_ctrl.sv
// Round-robin time-multiplexer for one shared resource: fixed-length grant windows,
// lock-based extension bounded by per-requester starvation watchdogs, and per-requester flush.
module resource_arbiter_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int MAX_WAIT    = 8,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [NUM_REQ-1:0] flush,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    owner_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] stall,
  output logic [NUM_REQ-1:0] starved,
  output logic               fsm_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [ID_W-1:0]    owner_n;
  logic               busy_n;
  logic [ID_W-1:0]    ptr, ptr_n, ptr_inc, win;
  logic [7:0]         hold_cnt, hold_n;
  logic [CNT_W-1:0]   wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] ereq;
  logic               other_starved;

  assign ereq          = req & ~flush;
  assign stall         = ereq & ~grant;
  assign other_starved = |(starved & ~grant);
  assign fsm_state     = logic'(state);

  // Starved requesters take absolute priority (lowest index); otherwise circular search from p.
  function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [NUM_REQ-1:0] s,
                                                  input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] starve_idx, hi_idx, lo_idx;
    logic            starve_hit, hi_hit;
    starve_idx = '0;
    hi_idx     = '0;
    lo_idx     = '0;
    starve_hit = 1'b0;
    hi_hit     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i] && s[i]) begin
        starve_idx = ID_W'(i);
        starve_hit = 1'b1;
      end
      if (r[i] && (i >= int'(p))) begin
        hi_idx = ID_W'(i);
        hi_hit = 1'b1;
      end
      if (r[i]) lo_idx = ID_W'(i);
    end
    if (starve_hit)  return starve_idx;
    else if (hi_hit) return hi_idx;
    else             return lo_idx;
  endfunction

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner_id;
    busy_n  = busy;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    ptr_inc = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + ID_W'(1);
    // On a release the search already starts from the advanced pointer.
    win     = pick_winner(ereq, starved, (state == HOLD) ? ptr_inc : ptr);
    case (state)
      IDLE: begin
        if (|ereq) begin
          state_n = HOLD;
          grant_n = NUM_REQ'(1) << win;
          owner_n = win;
          busy_n  = 1'b1;
          hold_n  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (!ereq[owner_id]) begin
          // Abort beats window end: no re-arbitration on this edge.
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = ptr_inc;
        end else if (hold_cnt != 8'd0) begin
          hold_n = hold_cnt - 8'd1;
        end else if (lock[owner_id] && !other_starved) begin
          hold_n = HOLD_LOAD;
        end else begin
          ptr_n = ptr_inc;
          if (|ereq) begin
            grant_n = NUM_REQ'(1) << win;
            owner_n = win;
            hold_n  = HOLD_LOAD;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner_id <= owner_n;
      busy     <= busy_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  // Wait counters saturate at MAX_WAIT; starved lags the counter by one cycle and clears with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starved <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] || !ereq[i]) begin
          wait_cnt[i] <= '0;
          starved[i]  <= 1'b0;
        end else begin
          if (wait_cnt[i] != MAX_CNT) wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
          starved[i] <= (wait_cnt[i] == MAX_CNT);
        end
      end
    end
  end

endmodule

// File: tb/tb_resource_arbiter_ctrl.sv
// Bench for resource_arbiter_ctrl with NUM_REQ=2, HOLD_CYCLES=3, MAX_WAIT=4.
module tb_resource_arbiter_ctrl;

  localparam int NR = 2;
  localparam int HC = 3;
  localparam int MW = 4;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req, lock, flush;
  logic [NR-1:0] grant, stall, starved;
  logic [IW-1:0] owner_id;
  logic          busy, fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [NR-1:0] exp_q [$];
  logic [NR-1:0] exp_s_q [$];

  resource_arbiter_ctrl #(
    .NUM_REQ(NR), .HOLD_CYCLES(HC), .MAX_WAIT(MW), .ID_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .flush(flush),
    .grant(grant), .owner_id(owner_id), .busy(busy), .stall(stall),
    .starved(starved), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req   = '0;
    lock  = '0;
    flush = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_s_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req   = 2'b11;
    lock  = 2'b00;
    flush = 2'b01;
    #3;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (owner_id !== 1'b0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner_id); end
    checks++; if (starved !== 2'b00) begin failures++; $display("FAIL reset_starved got=%b exp=00", starved); end
    checks++; if (fsm_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", fsm_state); end
    checks++; if (stall !== 2'b10) begin failures++; $display("FAIL reset_stall got=%b exp=10", stall); end
  endtask

  task automatic test_single_grant;
    logic [NR-1:0] req_t [5];
    logic [NR-1:0] exp_t [5];
    logic [NR-1:0] e;
    do_reset();
    req_t = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    exp_t = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_c0_grant got=%b exp=00", grant); end
    for (int c = 0; c < 5; c++) begin
      req = req_t[c];
      exp_q.push_back(exp_t[c]);
      tick();
      e = exp_q.pop_front();
      checks++; if (grant !== e) begin failures++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", c + 1, grant, e); end
      checks++; if (busy !== (|e)) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c + 1, busy, |e); end
      if (e != 2'b00) begin
        checks++; if (owner_id !== 1'b0) begin failures++; $display("FAIL single_owner cyc=%0d got=%0d exp=0", c + 1, owner_id); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [NR-1:0] exp_t [10];
    logic [NR-1:0] e;
    do_reset();
    exp_t = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int c = 0; c < 10; c++) begin
      req = 2'b11;
      exp_q.push_back(exp_t[c]);
      tick();
      e = exp_q.pop_front();
      checks++; if (grant !== e) begin failures++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", c + 1, grant, e); end
      checks++; if (stall !== ~e) begin failures++; $display("FAIL b2b_stall cyc=%0d got=%b exp=%b", c + 1, stall, ~e); end
      checks++; if (owner_id !== e[1]) begin failures++; $display("FAIL b2b_owner cyc=%0d got=%0d exp=%0d", c + 1, owner_id, e[1]); end
    end
  endtask

  task automatic test_lock_starve;
    logic [NR-1:0] exp_t [10];
    logic [NR-1:0] exp_s [10];
    logic [NR-1:0] e, es;
    do_reset();
    exp_t = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    exp_s = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int c = 0; c < 10; c++) begin
      req  = 2'b11;
      lock = 2'b01;
      exp_q.push_back(exp_t[c]);
      exp_s_q.push_back(exp_s[c]);
      tick();
      e  = exp_q.pop_front();
      es = exp_s_q.pop_front();
      checks++; if (grant !== e) begin failures++; $display("FAIL lock_grant cyc=%0d got=%b exp=%b", c + 1, grant, e); end
      checks++; if (starved !== es) begin failures++; $display("FAIL lock_starved cyc=%0d got=%b exp=%b", c + 1, starved, es); end
    end
    lock = 2'b00;
  endtask

  task automatic test_owner_flush;
    logic [NR-1:0] flush_t [6];
    logic [NR-1:0] exp_t [6];
    logic [NR-1:0] e;
    do_reset();
    flush_t = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    exp_t   = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
    for (int c = 0; c < 6; c++) begin
      req   = 2'b11;
      flush = flush_t[c];
      #1;
      if (c == 2) begin
        checks++; if (stall !== 2'b10) begin failures++; $display("FAIL flush_stall cyc=2 got=%b exp=10", stall); end
      end
      exp_q.push_back(exp_t[c]);
      tick();
      e = exp_q.pop_front();
      checks++; if (grant !== e) begin failures++; $display("FAIL flush_grant cyc=%0d got=%b exp=%b", c + 1, grant, e); end
      checks++; if (busy !== (|e)) begin failures++; $display("FAIL flush_busy cyc=%0d got=%b exp=%b", c + 1, busy, |e); end
    end
    flush = 2'b00;
  endtask

  task automatic test_nonowner_flush;
    logic [NR-1:0] e, es;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req   = 2'b11;
      flush = 2'b10;
      exp_q.push_back(2'b01);
      exp_s_q.push_back(2'b00);
      tick();
      e  = exp_q.pop_front();
      es = exp_s_q.pop_front();
      checks++; if (grant !== e) begin failures++; $display("FAIL nflush_grant cyc=%0d got=%b exp=%b", c + 1, grant, e); end
      checks++; if (stall !== 2'b00) begin failures++; $display("FAIL nflush_stall cyc=%0d got=%b exp=00", c + 1, stall); end
      checks++; if (starved !== es) begin failures++; $display("FAIL nflush_starved cyc=%0d got=%b exp=%b", c + 1, starved, es); end
    end
    flush = 2'b00;
  endtask

  task automatic test_async_reset;
    do_reset();
    req = 2'b11;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL areset_pre_grant got=%b exp=01", grant); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL areset_grant got=%b exp=00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (starved !== 2'b00) begin failures++; $display("FAIL areset_starved got=%b exp=00", starved); end
    req = 2'b10;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL areset_release_grant got=%b exp=00", grant); end
    exp_q.push_back(2'b10);
    tick();
    checks++; if (grant !== exp_q[0]) begin failures++; $display("FAIL areset_regrant got=%b exp=%b", grant, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (owner_id !== 1'b1) begin failures++; $display("FAIL areset_owner got=%0d exp=1", owner_id); end
  endtask

  task automatic test_random_invariants;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      req   = 2'($urandom_range(0, 3));
      lock  = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      #1;
      checks++; if (stall !== (req & ~flush & ~grant)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, req & ~flush & ~grant); end
      tick();
      checks++; if (!$onehot0(grant)) begin failures++; $display("FAIL rnd_onehot cyc=%0d grant=%b", c, grant); end
      checks++; if (busy !== (|grant)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, |grant); end
      if (grant != 2'b00) begin
        checks++; if (owner_id !== grant[1]) begin failures++; $display("FAIL rnd_owner cyc=%0d got=%0d exp=%0d", c, owner_id, grant[1]); end
      end
    end
    req   = '0;
    lock  = '0;
    flush = '0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_lock_starve();
    test_owner_flush();
    test_nonowner_flush();
    test_async_reset();
    test_random_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
